// File: rtl/tag_stamper.sv
// Time-tagger: stamps rising edges of det with a free-running counter and queues them on a valid/ready stream.
// Optional macro TAG_SYNC_EN adds a 2-flop synchronizer on det (stamps then land 2 counts later).
module tag_stamper #(
  parameter int iSIZE       = 31,
  parameter int fifoAddrBit = 3,
  parameter int deadCycles  = 4,
  parameter int dropBit     = 15
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             det,
  input  logic             en,
  output logic [iSIZE:0]   tDat,
  output logic             tV,
  input  logic             tR,
  output logic [dropBit:0] dropCnt,
  output logic [iSIZE:0]   cnt
);

  localparam int AW    = fifoAddrBit + 1;
  localparam int DEPTH = 2 ** AW;
  localparam int DW    = (deadCycles > 2) ? $clog2(deadCycles) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = (deadCycles > 1) ? DW'(deadCycles - 1) : '0;
  localparam logic [AW:0]   FULL_PTS  = {1'b1, {AW{1'b0}}};

  logic [iSIZE:0]   cnt_q, cnt_d;
  logic             det_pre_q;
  logic [DW-1:0]    dead_q, dead_d;
  logic [dropBit:0] drop_q, drop_d;
  logic [AW-1:0]    ra_q, ra_d;
  logic [AW:0]      val_pts_q, val_pts_d;
  logic [iSIZE:0]   mem_q [DEPTH];

  logic          det_in;
  logic          edge_det;
  logic          try_wr;
  logic          wr;
  logic          rd;
  logic          drop;
  logic          full;
  logic [AW-1:0] wa;

`ifdef TAG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], det};
    end
  end

  assign det_in = sync_q[1];
`else
  assign det_in = det;
`endif

  assign tV   = (val_pts_q != '0);
  assign full = (val_pts_q == FULL_PTS);
  assign rd   = tV && tR;
  // Low address bits wrap, so when full the write slot aliases the head being read out.
  assign wa   = ra_q + val_pts_q[AW-1:0];

  assign edge_det = det_in && !det_pre_q;
  assign try_wr   = edge_det && en && (dead_q == '0);
  assign wr       = try_wr && (!full || rd);
  assign drop     = try_wr && full && !rd;

  assign tDat    = tV ? mem_q[ra_q] : '0;
  assign dropCnt = drop_q;
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d     = cnt_q + (iSIZE + 1)'(1);
    ra_d      = ra_q;
    val_pts_d = val_pts_q;
    dead_d    = dead_q;
    drop_d    = drop_q;

    if (rd) begin
      ra_d = ra_q + AW'(1);
    end

    case ({wr, rd})
      2'b10:   val_pts_d = val_pts_q + (AW + 1)'(1);
      2'b01:   val_pts_d = val_pts_q - (AW + 1)'(1);
      default: val_pts_d = val_pts_q;
    endcase

    // Dead time starts only from an accepted edge; drops leave the timer idle.
    if (wr) begin
      dead_d = DEAD_LOAD;
    end else if (dead_q != '0) begin
      dead_d = dead_q - DW'(1);
    end

    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + (dropBit + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q     <= '0;
      det_pre_q <= 1'b0;
      dead_q    <= '0;
      drop_q    <= '0;
      ra_q      <= '0;
      val_pts_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      det_pre_q <= det_in;
      dead_q    <= dead_d;
      drop_q    <= drop_d;
      ra_q      <= ra_d;
      val_pts_q <= val_pts_d;
    end
  end

  // Storage needs no reset: occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wa] <= cnt_q;
    end
  end

endmodule
